hsi_m_rx_reply_ctrl: RTL and testbench
======================================

Name: hsi_m_rx_reply_ctrl

Overview:
- Master-side reply receiver, directly downstream of the master TX controller.
- The TX controller pulses frame_to_reply_end when the CRC of an SR, DPR or CCW command frame finishes. This block then opens a reply window and collects decoded bytes from the line decoder.
- It checks length and CRC16-CCITT, forwards payload bytes, and reports one completion status per command.

Parameters:
SR_LEN, 4, SR reply payload bytes (excl. 2 CRC bytes), 1..255
DPR_LEN, 6, DPR reply payload bytes, 1..255
CCW_LEN, 2, CCW reply payload bytes, 1..255
T_FIRST, 2000, clk cycles from window open to first byte before timeout, 1..65535
T_BYTE, 400, max clk cycles between consecutive bytes, 1..65535

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
frame_to_reply_end  in  1  1-cycle pulse: command frame needing reply fully sent
reply_cmd  in  3  one-hot {CCW,DPR,SR}, sampled with frame_to_reply_end
dc_q  in  8  decoded byte from line decoder
dc_q_rdy  in  1  1-cycle strobe, dc_q valid
dc_err  in  1  1-cycle line-code/framing error strobe from decoder
rx_byte  out  8  payload byte
rx_byte_vld  out  1  1-cycle strobe per payload byte (CRC bytes never forwarded)
rx_byte_idx  out  8  index of rx_byte within payload, from 0
rx_type  out  3  one-hot command type of the current/last window
busy  out  1  window open (WAIT_FIRST or RECV)
done  out  1  1-cycle completion pulse
status  out  2  valid with done: 0 OK, 1 CRC_ERR, 2 TIMEOUT, 3 LINE_ERR
unsol  out  1  1-cycle pulse: byte received while IDLE, dropped

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0; CRC register 16'hFFFF. Reset mid-window aborts silently: no done pulse.
- CRC16-CCITT: poly 0x1021, init 0xFFFF, MSB-first, no reflection, no final XOR.
  - Covers payload and both CRC bytes; the CRC is sent high byte first.
  - Residue 0x0000 = OK.
- States:
  - IDLE:
    - frame_to_reply_end=1 with reply_cmd nonzero: latch LEN for the type, rx_type <= reply_cmd, clear byte counter, CRC <= FFFF, timer <= 0, go WAIT_FIRST.
    - reply_cmd not one-hot: priority SR > DPR > CCW.
    - reply_cmd = 0: ignore the pulse.
    - dc_q_rdy in IDLE: unsol pulse next cycle, byte dropped.
  - WAIT_FIRST:
    - Timer increments each cycle.
    - dc_q_rdy: go RECV, processing the byte as in RECV.
    - Timer reaches T_FIRST-1 without a byte: done with TIMEOUT, go IDLE.
  - RECV:
    - Each dc_q_rdy: CRC updated with dc_q, counter++, inter-byte timer cleared.
    - Byte index < LEN: rx_byte/rx_byte_vld/rx_byte_idx registered, one cycle after dc_q_rdy.
    - Counter reaches LEN+2: go CHECK.
    - Inter-byte timer reaches T_BYTE-1: done with TIMEOUT, go IDLE.
  - CHECK (1 cycle): done, status OK if CRC == 0 else CRC_ERR; go IDLE.
- Latency:
  - done occurs 2 cycles after the last CRC byte strobe.
  - TIMEOUT done occurs on the cycle after the timer hits its limit.
- dc_err in WAIT_FIRST/RECV: done with LINE_ERR next cycle, go IDLE. dc_err in IDLE is ignored.
- Simultaneous events:
  - dc_err and dc_q_rdy together: error wins, byte not forwarded.
  - Timeout and dc_q_rdy in the same cycle: byte wins, timer cleared.
- frame_to_reply_end while busy: ignored; the current window continues.
- Bytes arriving in CHECK: treated as in IDLE (unsol).
- Exactly one done pulse per accepted window.
- Timer 16 bits, saturating at limit; byte counter 9 bits.

Decomposition:
- Package hsi_rx_pkg holds:
  - status codes (RX_OK, RX_CRC_ERR, RX_TIMEOUT, RX_LINE_ERR);
  - the state encoding;
  - CRC16-CCITT byte-update function crc16_ccitt_byte(crc, d) and constants CRC_INIT=16'hFFFF, POLY=16'h1021.
- One natural sub-module: rx_window_timer (sync clear, enable, programmable limit, hit output), shared by both timeouts.

Test Plan:
- OK frame: SR_LEN=9, reply_cmd=001, bytes 31..39 then 29 B1 (CRC of "123456789" = 0x29B1) -> 9 rx_byte_vld with idx 0..8, done with status 0, rx_type=001.
- CRC error: same stream with last byte B0 -> 9 payload strobes, done with status 1.
- First-byte timeout: T_FIRST=100, window opened, no bytes -> done with status 2 exactly 100 cycles after entering WAIT_FIRST, busy falls.
- Inter-byte timeout and line error:
  - DPR_LEN=6, 3 bytes then silence T_BYTE -> status 2.
  - Repeat with dc_err after byte 2 -> status 3, no further rx_byte_vld.
- Window-open edge cases:
  - frame_to_reply_end while busy -> ignored, single done.
  - Byte in IDLE -> unsol=1, no rx_byte_vld.
  - reply_cmd=000 -> stays IDLE.
- Reset mid-RECV: rst after 2 bytes -> all outputs 0, no done; a new window then completes OK.

Source files
------------

// File: rtl/hsi_rx_pkg.sv
// Shared types and CRC helper for the master-side reply receiver.
package hsi_rx_pkg;

    typedef enum logic [1:0] {
        RX_OK       = 2'd0,
        RX_CRC_ERR  = 2'd1,
        RX_TIMEOUT  = 2'd2,
        RX_LINE_ERR = 2'd3
    } rx_status_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_FIRST,
        ST_RECV,
        ST_CHECK
    } rx_state_e;

    localparam logic [15:0] CRC_INIT = 16'hFFFF;
    localparam logic [15:0] POLY     = 16'h1021;

    // CRC16-CCITT, MSB-first, one byte per call.
    function automatic logic [15:0] crc16_ccitt_byte(input logic [15:0] crc, input logic [7:0] d);
        logic [15:0] c;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            if (c[15] ^ d[i]) c = {c[14:0], 1'b0} ^ POLY;
            else              c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/rx_window_timer.sv
// Saturating cycle timer; hit is high while the count sits at limit-1.
module rx_window_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic [15:0] limit,
    output logic        hit
);
    logic [15:0] cnt_q, cnt_d;

    assign hit = (cnt_q == (limit - 16'd1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr)              cnt_d = 16'd0;
        else if (en && !hit)  cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= 16'd0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/hsi_m_rx_reply_ctrl.sv
// Reply receiver: opens a window after a command frame, collects and CRC-checks
// the reply, forwards payload bytes and reports one completion status.
module hsi_m_rx_reply_ctrl
    import hsi_rx_pkg::*;
#(
    parameter int unsigned SR_LEN  = 4,
    parameter int unsigned DPR_LEN = 6,
    parameter int unsigned CCW_LEN = 2,
    parameter int unsigned T_FIRST = 2000,
    parameter int unsigned T_BYTE  = 400
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_to_reply_end,
    input  logic [2:0] reply_cmd,
    input  logic [7:0] dc_q,
    input  logic       dc_q_rdy,
    input  logic       dc_err,
    output logic [7:0] rx_byte,
    output logic       rx_byte_vld,
    output logic [7:0] rx_byte_idx,
    output logic [2:0] rx_type,
    output logic       busy,
    output logic       done,
    output logic [1:0] status,
    output logic       unsol
);
    rx_state_e  state_q, state_d;
    rx_status_e status_q, status_d;
    logic [7:0]  len_q, len_d;
    logic [8:0]  cnt_q, cnt_d;
    logic [15:0] crc_q, crc_d;
    logic [7:0]  rx_byte_q, rx_byte_d, rx_byte_idx_q, rx_byte_idx_d;
    logic [2:0]  rx_type_q, rx_type_d;
    logic        rx_byte_vld_q, rx_byte_vld_d, busy_q, busy_d;
    logic        done_q, done_d, unsol_q, unsol_d;
    logic        tmr_clr, tmr_en, tmr_hit;
    logic [15:0] tmr_limit;

    rx_window_timer u_timer (
        .clk   (clk),
        .rst   (rst),
        .clr   (tmr_clr),
        .en    (tmr_en),
        .limit (tmr_limit),
        .hit   (tmr_hit)
    );

    always_comb begin
        state_d       = state_q;
        status_d      = status_q;
        len_d         = len_q;
        cnt_d         = cnt_q;
        crc_d         = crc_q;
        rx_byte_d     = rx_byte_q;
        rx_byte_idx_d = rx_byte_idx_q;
        rx_type_d     = rx_type_q;
        rx_byte_vld_d = 1'b0;
        done_d        = 1'b0;
        unsol_d       = 1'b0;
        tmr_clr       = 1'b0;
        tmr_en        = (state_q == ST_WAIT_FIRST) || (state_q == ST_RECV);
        tmr_limit     = (state_q == ST_WAIT_FIRST) ? 16'(T_FIRST) : 16'(T_BYTE);

        case (state_q)
            ST_IDLE: begin
                unsol_d = dc_q_rdy;
                if (frame_to_reply_end && (reply_cmd != 3'b000)) begin
                    state_d = ST_WAIT_FIRST;
                    cnt_d   = 9'd0;
                    crc_d   = CRC_INIT;
                    tmr_clr = 1'b1;
                    if (reply_cmd[0]) begin
                        len_d     = 8'(SR_LEN);
                        rx_type_d = 3'b001;
                    end else if (reply_cmd[1]) begin
                        len_d     = 8'(DPR_LEN);
                        rx_type_d = 3'b010;
                    end else begin
                        len_d     = 8'(CCW_LEN);
                        rx_type_d = 3'b100;
                    end
                end
            end
            ST_WAIT_FIRST, ST_RECV: begin
                // Line error beats a simultaneous byte, a byte beats a timeout.
                if (dc_err) begin
                    done_d   = 1'b1;
                    status_d = RX_LINE_ERR;
                    state_d  = ST_IDLE;
                end else if (dc_q_rdy) begin
                    state_d = ST_RECV;
                    crc_d   = crc16_ccitt_byte(crc_q, dc_q);
                    cnt_d   = cnt_q + 9'd1;
                    tmr_clr = 1'b1;
                    if (cnt_q < {1'b0, len_q}) begin
                        rx_byte_d     = dc_q;
                        rx_byte_vld_d = 1'b1;
                        rx_byte_idx_d = cnt_q[7:0];
                    end
                    if ((cnt_q + 9'd1) == ({1'b0, len_q} + 9'd2)) state_d = ST_CHECK;
                end else if (tmr_hit) begin
                    done_d   = 1'b1;
                    status_d = RX_TIMEOUT;
                    state_d  = ST_IDLE;
                end
            end
            ST_CHECK: begin
                unsol_d  = dc_q_rdy;
                done_d   = 1'b1;
                status_d = (crc_q == 16'h0000) ? RX_OK : RX_CRC_ERR;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_WAIT_FIRST) || (state_d == ST_RECV);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            status_q      <= RX_OK;
            len_q         <= 8'd0;
            cnt_q         <= 9'd0;
            crc_q         <= CRC_INIT;
            rx_byte_q     <= 8'd0;
            rx_byte_idx_q <= 8'd0;
            rx_type_q     <= 3'b000;
            rx_byte_vld_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            unsol_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            status_q      <= status_d;
            len_q         <= len_d;
            cnt_q         <= cnt_d;
            crc_q         <= crc_d;
            rx_byte_q     <= rx_byte_d;
            rx_byte_idx_q <= rx_byte_idx_d;
            rx_type_q     <= rx_type_d;
            rx_byte_vld_q <= rx_byte_vld_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            unsol_q       <= unsol_d;
        end
    end

    assign rx_byte     = rx_byte_q;
    assign rx_byte_vld = rx_byte_vld_q;
    assign rx_byte_idx = rx_byte_idx_q;
    assign rx_type     = rx_type_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign status      = status_q;
    assign unsol       = unsol_q;
endmodule

// File: tb/tb_hsi_m_rx_reply_ctrl.sv
// Scoreboard bench for hsi_m_rx_reply_ctrl: stimulus pushes expected bytes and
// completions, a negedge monitor pops and compares them.
module tb_hsi_m_rx_reply_ctrl;
    localparam int SR_LEN  = 9;
    localparam int DPR_LEN = 6;
    localparam int CCW_LEN = 2;
    localparam int T_FIRST = 100;
    localparam int T_BYTE  = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_to_reply_end = 1'b0;
    logic [2:0] reply_cmd = 3'b000;
    logic [7:0] dc_q = 8'h00;
    logic       dc_q_rdy = 1'b0;
    logic       dc_err = 1'b0;
    logic [7:0] rx_byte, rx_byte_idx;
    logic       rx_byte_vld, busy, done, unsol;
    logic [2:0] rx_type;
    logic [1:0] status;

    always #5 clk = ~clk;

    hsi_m_rx_reply_ctrl #(
        .SR_LEN(SR_LEN), .DPR_LEN(DPR_LEN), .CCW_LEN(CCW_LEN),
        .T_FIRST(T_FIRST), .T_BYTE(T_BYTE)
    ) dut (
        .clk(clk), .rst(rst),
        .frame_to_reply_end(frame_to_reply_end), .reply_cmd(reply_cmd),
        .dc_q(dc_q), .dc_q_rdy(dc_q_rdy), .dc_err(dc_err),
        .rx_byte(rx_byte), .rx_byte_vld(rx_byte_vld), .rx_byte_idx(rx_byte_idx),
        .rx_type(rx_type), .busy(busy), .done(done), .status(status), .unsol(unsol)
    );

    typedef struct { logic [7:0] b; logic [7:0] idx; } byte_exp_t;
    typedef struct { logic [1:0] st; logic [2:0] typ; int cyc; } done_exp_t;

    byte_exp_t qb[$];
    done_exp_t qd[$];
    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int unsol_seen = 0;
    int unsol_exp = 0;

    // "123456789" followed by its CRC16-CCITT 0x29B1
    logic [7:0] okv [11] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h29, 8'hB1};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (rx_byte_vld) begin
                if (qb.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_byte: got %0h idx %0d, required no strobe", rx_byte, rx_byte_idx);
                end else begin
                    byte_exp_t eb;
                    eb = qb.pop_front();
                    chk("rx_byte", rx_byte, eb.b);
                    chk("rx_byte_idx", rx_byte_idx, eb.idx);
                end
            end
            if (done) begin
                if (qd.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_done: got status %0d, required no done", status);
                end else begin
                    done_exp_t ed;
                    ed = qd.pop_front();
                    chk("status", status, ed.st);
                    chk("rx_type", rx_type, ed.typ);
                    chk("busy_at_done", busy, 0);
                    if (ed.cyc >= 0) chk("done_cycle", cyc, ed.cyc);
                end
            end
            if (unsol) unsol_seen++;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic open_win(input logic [2:0] cmd, output int c0);
        reply_cmd = cmd;
        frame_to_reply_end = 1'b1;
        c0 = cyc;
        tick();
        frame_to_reply_end = 1'b0;
        reply_cmd = 3'b000;
    endtask

    task automatic send(input logic [7:0] b, output int c0);
        dc_q = b;
        dc_q_rdy = 1'b1;
        c0 = cyc;
        tick();
        dc_q_rdy = 1'b0;
        tick();
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((qb.size() != 0 || qd.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        chk("drain_pending", qb.size() + qd.size(), 0);
        repeat (3) tick();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_rx_byte"}, rx_byte, 0);
        chk({tag, "_rx_byte_vld"}, rx_byte_vld, 0);
        chk({tag, "_rx_byte_idx"}, rx_byte_idx, 0);
        chk({tag, "_rx_type"}, rx_type, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_status"}, status, 0);
        chk({tag, "_unsol"}, unsol, 0);
    endtask

    // SR window with the known vector; optional second frame_to_reply_end mid-reply.
    task automatic run_sr(input logic [2:0] cmd, input logic [7:0] last, input logic [1:0] st, input bit mid_ftre);
        int c;
        for (int i = 0; i < SR_LEN; i++) qb.push_back('{okv[i], 8'(i)});
        qd.push_back('{st, 3'b001, -1});
        open_win(cmd, c);
        chk("busy_open", busy, 1);
        for (int i = 0; i < 11; i++) begin
            send((i == 10) ? last : okv[i], c);
            if (mid_ftre && i == 2) begin
                open_win(3'b100, c);
                chk("busy_mid", busy, 1);
            end
        end
        drain(100);
    endtask

    initial begin
        int c;
        repeat (3) tick();
        check_zero("reset");
        rst = 1'b0;
        tick();

        run_sr(3'b001, 8'hB1, 2'd0, 1'b0);
        run_sr(3'b001, 8'hB0, 2'd1, 1'b0);

        // First-byte timeout on a CCW window
        open_win(3'b100, c);
        qd.push_back('{2'd2, 3'b100, c + T_FIRST + 1});
        drain(300);

        // Inter-byte timeout after 3 of 6 DPR bytes
        for (int i = 0; i < 3; i++) qb.push_back('{8'hA0 + 8'(i), 8'(i)});
        open_win(3'b010, c);
        for (int i = 0; i < 3; i++) send(8'hA0 + 8'(i), c);
        qd.push_back('{2'd2, 3'b010, c + T_BYTE + 1});
        drain(100);

        // Line error arriving together with the third byte, then a stray byte in IDLE
        qb.push_back('{8'hB0, 8'd0});
        qb.push_back('{8'hB1, 8'd1});
        qd.push_back('{2'd3, 3'b010, -1});
        open_win(3'b010, c);
        send(8'hB0, c);
        send(8'hB1, c);
        dc_q = 8'hB2; dc_q_rdy = 1'b1; dc_err = 1'b1;
        tick();
        dc_q_rdy = 1'b0; dc_err = 1'b0;
        drain(20);
        chk("unsol_after_err", unsol_seen, unsol_exp);
        send(8'hC0, c);
        unsol_exp++;
        repeat (2) tick();
        chk("unsol_idle", unsol_seen, unsol_exp);

        run_sr(3'b001, 8'hB1, 2'd0, 1'b1);
        run_sr(3'b111, 8'hB1, 2'd0, 1'b0);

        open_win(3'b000, c);
        chk("busy_cmd0", busy, 0);
        repeat (5) tick();
        chk("busy_cmd0_later", busy, 0);

        // Reset in the middle of a reply, then a clean window
        qb.push_back('{okv[0], 8'd0});
        qb.push_back('{okv[1], 8'd1});
        open_win(3'b001, c);
        send(okv[0], c);
        send(okv[1], c);
        rst = 1'b1;
        tick();
        check_zero("midrst");
        tick();
        rst = 1'b0;
        repeat (T_BYTE + 5) tick();
        chk("midrst_no_done", qd.size(), 0);
        run_sr(3'b001, 8'hB1, 2'd0, 1'b0);

        chk("unsol_total", unsol_seen, unsol_exp);
        chk("queues_empty", qb.size() + qd.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
